conv_host_mem: RTL and testbench

- Synthesizable host-side memory responder for the CONV accelerator. It is the counterpart of CONV's initiator ports.
- Holds the 64x64 input image and serves it on iaddr/idata.
- Implements the five layer memories (L0 kernel0/1, L1 kernel0/1, L2 flatten) behind the crd/cwr/csel interface.
- Runs the ready/busy start handshake, then streams any bank out over a valid/ready dump port so results can be checked on-chip or on FPGA.

---
 rtl/conv_host_mem_if.sv | 38 +++
 rtl/conv_host_mem.sv | 221 ++++++++++++++++++++++
 tb/tb_conv_host_mem.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/conv_host_mem_if.sv
// ============================================================================
//  conv_host_mem_if
//  CONV initiator <-> host memory bus: start handshake, image read port and
//  layer memory read/write port.
//  Rev 1.0 - initial release
// ============================================================================
`default_nettype none

interface conv_host_mem_if #(
    parameter int DW = 20,
    parameter int AW = 12
);
    logic          ready;
    logic          busy;
    logic [AW-1:0] iaddr;
    logic [DW-1:0] idata;
    logic          crd;
    logic          cwr;
    logic [2:0]    csel;
    logic [AW-1:0] caddr_rd;
    logic [AW-1:0] caddr_wr;
    logic [DW-1:0] cdata_wr;
    logic [DW-1:0] cdata_rd;

    // CONV side
    modport master (
        input  ready, idata, cdata_rd,
        output busy, iaddr, crd, cwr, csel, caddr_rd, caddr_wr, cdata_wr
    );

    // host memory side
    modport slave (
        output ready, idata, cdata_rd,
        input  busy, iaddr, crd, cwr, csel, caddr_rd, caddr_wr, cdata_wr
    );
endinterface

`default_nettype wire

// File: rtl/conv_host_mem.sv
// ============================================================================
//  conv_host_mem
//  Host-side image/layer memory responder for CONV with a bank dump stream.
//  Optional access-error flag built when CONV_HOST_ACCERR_EN is defined.
//  Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module conv_host_mem #(
    parameter int DW       = 20,
    parameter int AW       = 12,
    parameter int L0_DEPTH = 4096,
    parameter int L1_DEPTH = 1024,
    parameter int L2_DEPTH = 2048
) (
    input  wire logic          clk,
    input  wire logic          reset,
    input  wire logic          img_we,
    input  wire logic [AW-1:0] img_addr,
    input  wire logic [DW-1:0] img_data,
    input  wire logic          start,
    conv_host_mem_if.slave     conv,
    output logic               done,
    input  wire logic          dump_req,
    input  wire logic [2:0]    dump_sel,
    output logic [DW-1:0]      dout,
    output logic [AW-1:0]      dout_addr,
    output logic               dout_valid,
    input  wire logic          dout_ready,
    output logic               dout_last,
    output logic               err
);

    localparam int c_L0_AW = $clog2(L0_DEPTH);
    localparam int c_L1_AW = $clog2(L1_DEPTH);
    localparam int c_L2_AW = $clog2(L2_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READY = 3'd1,
        S_RUN   = 3'd2,
        S_DONE  = 3'd3,
        S_DUMP  = 3'd4
    } state_t;

    state_t r_state, w_state_nxt;

    logic [DW-1:0] r_img   [2**AW];
    logic [DW-1:0] r_l0k0  [L0_DEPTH];
    logic [DW-1:0] r_l0k1  [L0_DEPTH];
    logic [DW-1:0] r_l1k0  [L1_DEPTH];
    logic [DW-1:0] r_l1k1  [L1_DEPTH];
    logic [DW-1:0] r_l2    [L2_DEPTH];

    logic [DW-1:0] r_idata, r_cdata_rd, r_dout;
    logic [AW-1:0] r_dout_addr;
    logic          r_done, r_dout_valid, r_dout_last, r_dump_issue, r_busy_q;
    logic [2:0]    r_dump_sel;

    logic          w_conv_act, w_dump_xfer;
    logic [2:0]    w_rd_sel;
    logic [AW-1:0] w_rd_addr, w_dump_raddr;
    logic [DW-1:0] w_rd_word;

    function automatic logic f_sel_ok(input logic [2:0] s);
        return (s != 3'd0) && (s <= 3'd5);
    endfunction

    function automatic int f_depth(input logic [2:0] s);
        case (s)
            3'd1, 3'd2: return L0_DEPTH;
            3'd3, 3'd4: return L1_DEPTH;
            3'd5:       return L2_DEPTH;
            default:    return 0;
        endcase
    endfunction

    assign w_conv_act  = (r_state == S_READY) || (r_state == S_RUN);
    assign w_dump_xfer = r_dout_valid && dout_ready;

    // The dump reads one word ahead so a transfer can be followed by new data
    // on the very next cycle.
    assign w_dump_raddr = r_dump_issue ? '0 : r_dout_addr + 1'b1;
    assign w_rd_sel     = (r_state == S_DUMP) ? r_dump_sel : conv.csel;
    assign w_rd_addr    = (r_state == S_DUMP) ? w_dump_raddr : conv.caddr_rd;

    always_comb begin
        w_rd_word = '0;
        case (w_rd_sel)
            3'd1:    w_rd_word = r_l0k0[w_rd_addr[c_L0_AW-1:0]];
            3'd2:    w_rd_word = r_l0k1[w_rd_addr[c_L0_AW-1:0]];
            3'd3:    w_rd_word = r_l1k0[w_rd_addr[c_L1_AW-1:0]];
            3'd4:    w_rd_word = r_l1k1[w_rd_addr[c_L1_AW-1:0]];
            3'd5:    w_rd_word = r_l2[w_rd_addr[c_L2_AW-1:0]];
            default: w_rd_word = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_READY;
            S_READY: if (conv.busy) w_state_nxt = S_RUN;
            S_RUN:   if (r_busy_q && !conv.busy) w_state_nxt = S_DONE;
            S_DONE: begin
                if (start)                                w_state_nxt = S_READY;
                else if (dump_req && f_sel_ok(dump_sel))  w_state_nxt = S_DUMP;
            end
            S_DUMP:  if (w_dump_xfer && r_dout_last) w_state_nxt = S_DONE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_idata      <= '0;
            r_cdata_rd   <= '0;
            r_done       <= 1'b0;
            r_dout       <= '0;
            r_dout_addr  <= '0;
            r_dout_valid <= 1'b0;
            r_dout_last  <= 1'b0;
            r_dump_issue <= 1'b0;
            r_dump_sel   <= 3'd0;
            r_busy_q     <= 1'b0;
        end else begin
            r_busy_q <= conv.busy;
            r_done   <= (r_state == S_RUN) && (w_state_nxt == S_DONE);
            if (r_state == S_RUN)
                r_idata <= r_img[conv.iaddr];
            if (w_conv_act && conv.crd)
                r_cdata_rd <= w_rd_word;
            if ((r_state == S_DONE) && (w_state_nxt == S_DUMP)) begin
                r_dump_sel   <= dump_sel;
                r_dump_issue <= 1'b1;
            end
            if (r_state == S_DUMP) begin
                if (r_dump_issue) begin
                    r_dump_issue <= 1'b0;
                    r_dout       <= w_rd_word;
                    r_dout_addr  <= '0;
                    r_dout_valid <= 1'b1;
                    r_dout_last  <= (f_depth(r_dump_sel) == 1);
                end else if (w_dump_xfer) begin
                    if (r_dout_last) begin
                        r_dout_valid <= 1'b0;
                        r_dout_last  <= 1'b0;
                    end else begin
                        r_dout      <= w_rd_word;
                        r_dout_addr <= w_dump_raddr;
                        r_dout_last <= (32'(w_dump_raddr) == 32'(f_depth(r_dump_sel) - 1));
                    end
                end
            end
        end
    end

    // Memory contents survive reset; only the write strobes are gated by it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if ((r_state == S_IDLE) && img_we)
                r_img[img_addr] <= img_data;
            if (w_conv_act && conv.cwr) begin
                case (conv.csel)
                    3'd1:    r_l0k0[conv.caddr_wr[c_L0_AW-1:0]] <= conv.cdata_wr;
                    3'd2:    r_l0k1[conv.caddr_wr[c_L0_AW-1:0]] <= conv.cdata_wr;
                    3'd3:    r_l1k0[conv.caddr_wr[c_L1_AW-1:0]] <= conv.cdata_wr;
                    3'd4:    r_l1k1[conv.caddr_wr[c_L1_AW-1:0]] <= conv.cdata_wr;
                    3'd5:    r_l2[conv.caddr_wr[c_L2_AW-1:0]]   <= conv.cdata_wr;
                    default: ;
                endcase
            end
        end
    end

`ifdef CONV_HOST_ACCERR_EN
    logic r_err, w_acc_err;

    always_comb begin
        w_acc_err = 1'b0;
        if (w_conv_act && (conv.crd || conv.cwr)) begin
            if (!f_sel_ok(conv.csel))
                w_acc_err = 1'b1;
            else begin
                if (conv.crd && (32'(conv.caddr_rd) >= 32'(f_depth(conv.csel))))
                    w_acc_err = 1'b1;
                if (conv.cwr && (32'(conv.caddr_wr) >= 32'(f_depth(conv.csel))))
                    w_acc_err = 1'b1;
                if (conv.crd && conv.cwr)
                    w_acc_err = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) r_err <= 1'b0;
        else       r_err <= r_err | w_acc_err;
    end

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

    assign conv.ready    = (r_state == S_READY);
    assign conv.idata    = r_idata;
    assign conv.cdata_rd = r_cdata_rd;
    assign done          = r_done;
    assign dout          = r_dout;
    assign dout_addr     = r_dout_addr;
    assign dout_valid    = r_dout_valid;
    assign dout_last     = r_dout_last;

endmodule

`default_nettype wire

// File: tb/tb_conv_host_mem.sv
// ============================================================================
//  tb_conv_host_mem
//  Directed self-checking bench: handshake, image/layer access, bank dump.
//  Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_conv_host_mem;

`ifdef CONV_HOST_ACCERR_EN
    localparam bit c_ACC = 1'b1;
`else
    localparam bit c_ACC = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        img_we;
    logic [11:0] img_addr;
    logic [19:0] img_data;
    logic        start;
    logic        done;
    logic        dump_req;
    logic [2:0]  dump_sel;
    logic [19:0] dout;
    logic [11:0] dout_addr;
    logic        dout_valid;
    logic        dout_ready;
    logic        dout_last;
    logic        err;

    int n_total = 0;
    int n_bad   = 0;
    logic [19:0] m_l1k0 [1024];
    logic        exp_err;

    conv_host_mem_if #(.DW(20), .AW(12)) bus ();

    conv_host_mem dut (
        .clk        (clk),
        .reset      (reset),
        .img_we     (img_we),
        .img_addr   (img_addr),
        .img_data   (img_data),
        .start      (start),
        .conv       (bus),
        .done       (done),
        .dump_req   (dump_req),
        .dump_sel   (dump_sel),
        .dout       (dout),
        .dout_addr  (dout_addr),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .dout_last  (dout_last),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"}, 32'(bus.ready), 0);
        check({tag, "_idata"}, 32'(bus.idata), 0);
        check({tag, "_cdata"}, 32'(bus.cdata_rd), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_dout"}, 32'(dout), 0);
        check({tag, "_daddr"}, 32'(dout_addr), 0);
        check({tag, "_dvalid"}, 32'(dout_valid), 0);
        check({tag, "_dlast"}, 32'(dout_last), 0);
        check({tag, "_err"}, 32'(err), 0);
    endtask

    // Bring a fresh run from IDLE/DONE through READY and RUN into DONE.
    task automatic quick_run();
        start = 1'b1; tick(); start = 1'b0;
        bus.busy = 1'b1; tick(); tick();
        bus.busy = 1'b0; tick();
        check("run_done", 32'(done), 1);
        tick();
    endtask

    // Dump L1 kernel0 and compare each presented word with the model.
    task automatic dump_l1k0(input bit toggle);
        int cnt = 0;
        dump_sel = 3'd3; dump_req = 1'b1; tick(); dump_req = 1'b0;
        check("dump_issue_valid", 32'(dout_valid), 0);
        tick();
        check("dump_first_valid", 32'(dout_valid), 1);
        for (int cyc = 0; cyc < 4000 && cnt < 1024; cyc++) begin
            dout_ready = toggle ? cyc[0] : 1'b1;
            if (dout_valid) begin
                check("dump_addr", 32'(dout_addr), 32'(cnt));
                check("dump_data", 32'(dout), 32'(m_l1k0[cnt]));
                check("dump_last", 32'(dout_last), 32'(cnt == 1023));
                if (dout_ready) cnt++;
            end
            tick();
        end
        dout_ready = 1'b0;
        check("dump_count", 32'(cnt), 1024);
        check("dump_end_valid", 32'(dout_valid), 0);
    endtask

    initial begin
        reset = 1'b1; img_we = 1'b0; img_addr = '0; img_data = '0; start = 1'b0;
        dump_req = 1'b0; dump_sel = '0; dout_ready = 1'b0;
        bus.busy = 1'b0; bus.iaddr = '0; bus.crd = 1'b0; bus.cwr = 1'b0;
        bus.csel = '0; bus.caddr_rd = '0; bus.caddr_wr = '0; bus.cdata_wr = '0;
        exp_err = 1'b0;
        tick(); tick();
        check_all_zero("rst");
        reset = 1'b0;

        for (int k = 0; k < 4096; k++) begin
            img_we = 1'b1; img_addr = 12'(k); img_data = 20'(k); tick();
        end
        img_we = 1'b0;

        start = 1'b1; tick(); start = 1'b0;
        check("ready_after_start", 32'(bus.ready), 1);
        tick(); tick();
        check("ready_held", 32'(bus.ready), 1);

        // Fill L1 banks while READY: k1 zero, k0 with a known pattern.
        for (int a = 0; a < 1024; a++) begin
            bus.cwr = 1'b1; bus.csel = 3'd4; bus.caddr_wr = 12'(a); bus.cdata_wr = '0; tick();
            m_l1k0[a] = 20'(a * 131 + 7);
            bus.csel = 3'd3; bus.cdata_wr = m_l1k0[a]; tick();
        end
        bus.cwr = 1'b0;

        bus.busy = 1'b1;
        check("ready_before_busy_edge", 32'(bus.ready), 1);
        tick();
        check("ready_drop_run", 32'(bus.ready), 0);

        bus.iaddr = 12'h123; tick();
        check("idata_123", 32'(bus.idata), 32'h00123);
        bus.iaddr = 12'hFFF; tick();
        check("idata_fff", 32'(bus.idata), 32'h00FFF);
        img_we = 1'b1; img_addr = 12'h123; img_data = 20'h99999; tick(); img_we = 1'b0;
        bus.iaddr = 12'h123; tick();
        check("img_we_ignored", 32'(bus.idata), 32'h00123);

        bus.cwr = 1'b1; bus.csel = 3'd3; bus.caddr_wr = 12'd5; bus.cdata_wr = 20'h0ABCD; tick();
        m_l1k0[5] = 20'h0ABCD;
        bus.cwr = 1'b0; bus.crd = 1'b1; bus.caddr_rd = 12'd5; tick();
        check("l1k0_rd5", 32'(bus.cdata_rd), 32'h0ABCD);
        bus.crd = 1'b0; bus.csel = 3'd4; tick();
        check("cdata_hold", 32'(bus.cdata_rd), 32'h0ABCD);
        bus.crd = 1'b1; tick();
        check("l1k1_rd5", 32'(bus.cdata_rd), 32'h00000);

        bus.crd = 1'b0; bus.cwr = 1'b1; bus.csel = 3'd1; bus.caddr_wr = 12'd7; bus.cdata_wr = 20'h00011; tick();
        bus.crd = 1'b1; bus.caddr_rd = 12'd7; bus.cdata_wr = 20'h00022; tick();
        exp_err = c_ACC;
        check("rbw_old", 32'(bus.cdata_rd), 32'h00011);
        bus.cwr = 1'b0; tick();
        check("rbw_new", 32'(bus.cdata_rd), 32'h00022);
        check("err_after_rw", 32'(err), 32'(exp_err));

        bus.cwr = 1'b1; bus.crd = 1'b0; bus.csel = 3'd5; bus.caddr_wr = 12'd2047; bus.cdata_wr = 20'h7FFFF; tick();
        bus.cwr = 1'b0; bus.crd = 1'b1; bus.caddr_rd = 12'd2047; tick();
        check("l2_rd2047", 32'(bus.cdata_rd), 32'h7FFFF);

        bus.crd = 1'b0; bus.cwr = 1'b1; bus.csel = 3'd6; bus.cdata_wr = 20'h12345; tick();
        exp_err = c_ACC;
        bus.cwr = 1'b0; bus.crd = 1'b1; tick();
        check("bad_sel_rd", 32'(bus.cdata_rd), 32'h00000);
        check("err_bad_sel", 32'(err), 32'(exp_err));

        bus.crd = 1'b0; bus.cwr = 1'b1; bus.csel = 3'd3; bus.caddr_wr = 12'd1500; bus.cdata_wr = 20'h0F00D; tick();
        m_l1k0[476] = 20'h0F00D;
        bus.cwr = 1'b0; bus.crd = 1'b1; bus.caddr_rd = 12'd476; tick();
        check("wrap_1500", 32'(bus.cdata_rd), 32'h0F00D);
        bus.crd = 1'b0; tick();
        check("err_sticky", 32'(err), 32'(exp_err));

        bus.busy = 1'b0; tick();
        check("done_pulse", 32'(done), 1);
        check("done_ready", 32'(bus.ready), 0);
        tick();
        check("done_clear", 32'(done), 0);

        dump_sel = 3'd7; dump_req = 1'b1; tick(); dump_req = 1'b0; tick(); tick();
        check("bad_dump_ignored", 32'(dout_valid), 0);

        dump_l1k0(1'b1);

        // Abort a dump partway through with reset.
        dump_sel = 3'd3; dump_req = 1'b1; tick(); dump_req = 1'b0; dout_ready = 1'b1;
        for (int cyc = 0; cyc < 1000 && !(dout_valid && dout_addr == 12'd300); cyc++) tick();
        check("dump_reach_300", 32'(dout_addr), 300);
        dout_ready = 1'b0; reset = 1'b1; tick();
        check_all_zero("rst_dump");
        reset = 1'b0;
        dump_req = 1'b1; tick(); dump_req = 1'b0; tick(); tick();
        check("idle_no_dump", 32'(dout_valid), 0);

        quick_run();
        dump_l1k0(1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
